// File: rtl/cvxif_copro_pkg.sv
// Shared types for the CV-X-IF MAC coprocessor: opcode, op encoding, buffer entry, FSM states.
package cvxif_copro_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    typedef enum logic [2:0] {
        OpXpopc   = 3'b000,
        OpXmac    = 3'b001,
        OpXaccclr = 3'b010,
        OpXaccrd  = 3'b011
    } op_e;

    typedef struct packed {
        logic        committed;
        logic        killed;
        op_e         op;
        logic [4:0]  rd;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResult
    } state_e;

    function automatic logic [31:0] popcount32(input logic [31:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cvxif_copro_mul_iter.sv
// Radix-4 iterative 32x32->32 multiplier: two multiplier bits per cycle, 16 cycles per product.
module cvxif_copro_mul_iter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic [31:0] mcand_q, mplier_q, acc_q;
    logic [31:0] partial, sum;
    logic [3:0]  cnt_q;
    logic        busy_q;

    always_comb begin
        case (mplier_q[1:0])
            2'd0:    partial = '0;
            2'd1:    partial = mcand_q;
            2'd2:    partial = {mcand_q[30:0], 1'b0};
            default: partial = mcand_q + {mcand_q[30:0], 1'b0};
        endcase
    end

    assign sum       = acc_q + partial;
    // Product is taken combinationally during the 16th step.
    assign done_o    = busy_q && (cnt_q == 4'd15);
    assign product_o = sum;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= sum;
            mcand_q  <= {mcand_q[29:0], 2'b00};
            mplier_q <= {2'b00, mplier_q[31:2]};
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cvxif_mac_copro.sv
// CV-X-IF coprocessor: buffers CUSTOM-0 ops until commit, executes in order, one accumulator.
// Define CVXIF_MAC_FAST_EN for a single-cycle XMAC multiplier (EXEC state bypassed).
module cvxif_mac_copro
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4,
    parameter logic [31:0] ACC_RST  = 32'd0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [31:0]         issue_rs0_i,
    input  logic [31:0]         issue_rs1_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                busy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    entry_t              buf_q [DEPTH];
    logic [ID_WIDTH-1:0] id_q  [DEPTH];
    logic [DEPTH-1:0]    vld_q;
    logic [PtrW-1:0]     head_q, tail_q;
    logic [PtrW:0]       count_q;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] res_id_q;
    logic [31:0]         res_data_q;
    logic [4:0]          res_rd_q;
    op_e                 res_op_q;
    logic [31:0]         acc_q;

    logic [2:0]  funct3;
    logic        dec_ok, rs_ok, full, push, pop, commit_new;
    entry_t      head;
    logic        head_vld, head_hit, head_kill, head_go;
    logic [31:0] op_result;
    logic        mul_done;
    logic [31:0] mul_product;
    logic        unused_instr;

    assign unused_instr = ^issue_instr_i[24:15];

    assign funct3 = issue_instr_i[14:12];
    assign dec_ok = (issue_instr_i[6:0] == OPCODE_CUSTOM0) && (issue_instr_i[31:25] == 7'd0)
                    && !funct3[2];

    always_comb begin
        rs_ok = 1'b1;
        case (funct3)
            OpXpopc: rs_ok = issue_rs_valid_i[0];
            OpXmac:  rs_ok = &issue_rs_valid_i;
            default: rs_ok = 1'b1;
        endcase
    end

    // No bypass on pop: a full buffer refuses issue even while the head drains.
    assign full              = (count_q == (PtrW + 1)'(DEPTH));
    assign issue_ready_o     = !rst_i && !full && (!dec_ok || rs_ok);
    assign issue_accept_o    = !rst_i && issue_valid_i && dec_ok;
    assign issue_writeback_o = issue_accept_o;
    assign push              = issue_valid_i && issue_ready_o && dec_ok;
    assign commit_new        = push && commit_valid_i && (commit_id_i == issue_id_i);

    // A commit/kill for the head in this cycle is acted on immediately.
    assign head      = buf_q[head_q];
    assign head_vld  = vld_q[head_q];
    assign head_hit  = commit_valid_i && (id_q[head_q] == commit_id_i)
                       && !head.committed && !head.killed;
    assign head_kill = head_vld && (head.killed || (head_hit && commit_kill_i));
    assign head_go   = head_vld && !head_kill && (head.committed || (head_hit && !commit_kill_i));

    always_comb begin
        op_result = acc_q;
        case (head.op)
            OpXpopc:   op_result = popcount32(head.rs1);
`ifdef CVXIF_MAC_FAST_EN
            OpXmac:    op_result = acc_q + head.rs1 * head.rs2;
`else
            OpXmac:    op_result = '0;
`endif
            OpXaccclr: op_result = '0;
            default:   op_result = acc_q;
        endcase
    end

`ifndef CVXIF_MAC_FAST_EN
    logic mul_start;

    cvxif_copro_mul_iter u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start),
        .a_i       (head.rs1),
        .b_i       (head.rs2),
        .done_o    (mul_done),
        .product_o (mul_product)
    );
`else
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (commit_valid_i && !commit_new) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (vld_q[i] && (id_q[i] == commit_id_i) && !buf_q[i].committed
                        && !buf_q[i].killed) begin
                        if (commit_kill_i) buf_q[i].killed <= 1'b1;
                        else               buf_q[i].committed <= 1'b1;
                    end
                end
            end
            if (push) begin
                buf_q[tail_q] <= '{committed: commit_new && !commit_kill_i,
                                   killed:    commit_new && commit_kill_i,
                                   op:        op_e'(funct3),
                                   rd:        issue_instr_i[11:7],
                                   rs1:       issue_rs0_i,
                                   rs2:       issue_rs1_i};
                id_q[tail_q]  <= issue_id_i;
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + 1'b1;
            end
            count_q <= count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (head_go) begin
`ifdef CVXIF_MAC_FAST_EN
                    state_d = StResult;
`else
                    state_d = (head.op == OpXmac) ? StExec : StResult;
`endif
                end
            end
            StExec:   if (mul_done) state_d = StResult;
            StResult: if (result_ready_i) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        pop = (state_q == StIdle) && (head_kill || head_go);
`ifndef CVXIF_MAC_FAST_EN
        mul_start = (state_q == StIdle) && head_go && (head.op == OpXmac);
`endif
        result_valid_o = !rst_i && (state_q == StResult);
        result_id_o    = rst_i ? '0 : res_id_q;
        result_data_o  = rst_i ? '0 : res_data_q;
        result_rd_o    = rst_i ? '0 : res_rd_q;
        result_we_o    = result_valid_o;
        busy_o         = !rst_i && ((count_q != '0) || (state_q != StIdle));
    end

    // Accumulator only changes when the core takes the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_id_q   <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
            res_op_q   <= OpXaccrd;
            acc_q      <= ACC_RST;
        end else begin
            if (pop && head_go) begin
                res_id_q   <= id_q[head_q];
                res_rd_q   <= head.rd;
                res_op_q   <= head.op;
                res_data_q <= op_result;
            end
            if ((state_q == StExec) && mul_done) begin
                res_data_q <= acc_q + mul_product;
            end
            if ((state_q == StResult) && result_ready_i) begin
                if (res_op_q == OpXmac)         acc_q <= res_data_q;
                else if (res_op_q == OpXaccclr) acc_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_mac_copro.sv
// Bench for cvxif_mac_copro: directed scenarios, then random traffic against a queue model.
module tb_cvxif_mac_copro;

    localparam int unsigned IDW     = 4;
    localparam logic [31:0] ACC_RST = 32'd0;
    localparam logic [6:0]  OPC     = 7'b0001011;

    logic           clk = 1'b0;
    logic           rst;
    logic           issue_valid, issue_ready;
    logic [31:0]    issue_instr;
    logic [IDW-1:0] issue_id;
    logic [31:0]    issue_rs0, issue_rs1;
    logic [1:0]     issue_rs_valid;
    logic           issue_accept, issue_writeback;
    logic           commit_valid, commit_kill;
    logic [IDW-1:0] commit_id;
    logic           result_valid, result_ready;
    logic [IDW-1:0] result_id;
    logic [31:0]    result_data;
    logic [4:0]     result_rd;
    logic           result_we, busy;

    always #5 clk = ~clk;

    cvxif_mac_copro #(.DEPTH(4), .ID_WIDTH(IDW), .ACC_RST(ACC_RST)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs0_i       (issue_rs0),
        .issue_rs1_i       (issue_rs1),
        .issue_rs_valid_i  (issue_rs_valid),
        .issue_accept_o    (issue_accept),
        .issue_writeback_o (issue_writeback),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_o    (result_valid),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id),
        .result_data_o     (result_data),
        .result_rd_o       (result_rd),
        .result_we_o       (result_we),
        .busy_o            (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, f3, rd, OPC};
    endfunction

    function automatic logic [4:0] rd_of(input logic [IDW-1:0] id);
        return 5'(id) + 5'd1;
    endfunction

    // All directed tasks start and end just after a rising edge.
    task automatic issue(input logic [2:0] f3, input logic [IDW-1:0] id,
                         input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        issue_valid = 1'b1;
        issue_instr = enc(f3, rd_of(id));
        issue_id = id;
        issue_rs0 = a;
        issue_rs1 = b;
        issue_rs_valid = 2'b11;
        @(negedge clk);
        while (!issue_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", issue_ready, 1);
        check("issue_accept", issue_accept, (f3 < 3'd4) ? 1 : 0);
        check("issue_writeback", issue_writeback, (f3 < 3'd4) ? 1 : 0);
        @(posedge clk);
        #1 issue_valid = 1'b0;
    endtask

    task automatic commit(input logic [IDW-1:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id = id;
        commit_kill = kill;
        @(posedge clk);
        #1 commit_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [IDW-1:0] id, input logic [31:0] data,
                               input int lat_exp, input int hold);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!result_valid && lat < 40);
        check("res_valid", result_valid, 1);
        check("res_latency", 32'(lat), 32'(lat_exp));
        check("res_id", 32'(result_id), 32'(id));
        check("res_data", result_data, data);
        check("res_rd", 32'(result_rd), 32'(rd_of(id)));
        check("res_we", result_we, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", result_valid, 1);
            check("hold_data", result_data, data);
            check("hold_id", 32'(result_id), 32'(id));
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
    endtask

    typedef struct {
        logic [IDW-1:0] id;
        logic [2:0]     f3;
        logic [31:0]    a;
        logic [31:0]    b;
        int             st;   // 0 pending, 1 committed, 2 killed
    } pend_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [31:0]    data;
    } res_t;

    pend_t       mq[$];
    res_t        eq[$];
    logic [31:0] macc;

    // Retire resolved entries in issue order, producing the expected result stream.
    task automatic resolve();
        pend_t p;
        res_t  r;
        while (mq.size() > 0 && mq[0].st != 0) begin
            p = mq.pop_front();
            if (p.st == 1) begin
                case (p.f3)
                    3'd0: r.data = 32'($countones(p.a));
                    3'd1: begin macc = macc + p.a * p.b; r.data = macc; end
                    3'd2: begin macc = 32'd0; r.data = 32'd0; end
                    default: r.data = macc;
                endcase
                r.id = p.id;
                eq.push_back(r);
            end
        end
    endtask

    initial begin
        int          cnt;
        int          cidx;
        int          cand[$];
        logic        have_instr, exp_acc, rs_ok, hold_prev;
        logic [31:0] cur_instr, cur_a, cur_b, prev_data;
        logic [IDW-1:0] next_id;
        logic [2:0]  f3;
        pend_t       np;

        rst = 1'b1;
        issue_valid = 1'b0;
        issue_instr = '0;
        issue_id = '0;
        issue_rs0 = '0;
        issue_rs1 = '0;
        issue_rs_valid = '0;
        commit_valid = 1'b0;
        commit_id = '0;
        commit_kill = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", issue_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_rvalid", result_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_ready", issue_ready, 1);
        check("idle_busy", busy, 0);
        @(posedge clk);
        #1;

        issue(3'd0, 4'd2, 32'hF0F0_0001, 32'd0);
        commit(4'd2, 1'b0);
        wait_result(4'd2, 32'd9, 1, 0);

        issue(3'd2, 4'd3, 32'd0, 32'd0);
        commit(4'd3, 1'b0);
        wait_result(4'd3, 32'd0, 1, 0);
        issue(3'd1, 4'd4, 32'd3, 32'd5);
        commit(4'd4, 1'b0);
        wait_result(4'd4, 32'd15, 17, 0);
        issue(3'd1, 4'd5, 32'd3, 32'd5);
        commit(4'd5, 1'b0);
        wait_result(4'd5, 32'd30, 17, 0);
        issue(3'd3, 4'd6, 32'd0, 32'd0);
        commit(4'd6, 1'b0);
        wait_result(4'd6, 32'd30, 1, 0);

        for (int i = 7; i < 11; i++) issue(3'd3, 4'(i), 32'd0, 32'd0);
        issue_valid = 1'b1;
        issue_instr = enc(3'd3, rd_of(4'd11));
        issue_id = 4'd11;
        @(negedge clk);
        check("full_ready", issue_ready, 0);
        check("full_busy", busy, 1);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        commit(4'd7, 1'b0);
        @(negedge clk);
        check("pop_ready", issue_ready, 1);
        wait_result(4'd7, 32'd30, 1, 0);
        for (int i = 8; i < 11; i++) begin
            commit(4'(i), 1'b0);
            wait_result(4'(i), 32'd30, 1, 0);
        end

        issue(3'd1, 4'd12, 32'd7, 32'd7);
        commit(4'd12, 1'b1);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (result_valid) cnt++;
        end
        check("kill_no_result", 32'(cnt), 0);
        check("kill_idle", busy, 0);
        @(posedge clk);
        #1;
        issue(3'd3, 4'd13, 32'd0, 32'd0);
        commit(4'd13, 1'b0);
        wait_result(4'd13, 32'd30, 1, 0);

        issue(3'd2, 4'd14, 32'd0, 32'd0);
        commit(4'd14, 1'b0);
        wait_result(4'd14, 32'd0, 1, 0);
        issue(3'd1, 4'd15, 32'd1, 32'd1);
        commit(4'd15, 1'b0);
        wait_result(4'd15, 32'd1, 17, 0);
        issue(3'd1, 4'd0, 32'hFFFF_FFFF, 32'd2);
        commit(4'd0, 1'b0);
        wait_result(4'd0, 32'hFFFF_FFFF, 17, 5);
        issue(3'd3, 4'd1, 32'd0, 32'd0);
        commit(4'd1, 1'b0);
        wait_result(4'd1, 32'hFFFF_FFFF, 1, 0);

        issue(3'd7, 4'd2, 32'd0, 32'd0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || result_valid) cnt++;
        end
        check("bad_op_busy", 32'(cnt), 0);
        @(posedge clk);
        #1;

        issue(3'd1, 4'd3, 32'd2, 32'd2);
        commit(4'd3, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_exec_busy", busy, 0);
        check("rst_exec_rvalid", result_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;
        issue(3'd3, 4'd4, 32'd0, 32'd0);
        commit(4'd4, 1'b0);
        wait_result(4'd4, ACC_RST, 1, 0);

        issue_valid = 1'b1;
        issue_instr = enc(3'd3, rd_of(4'd5));
        issue_id = 4'd5;
        issue_rs_valid = 2'b11;
        commit_valid = 1'b1;
        commit_id = 4'd5;
        commit_kill = 1'b0;
        @(negedge clk);
        check("same_cycle_ready", issue_ready, 1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        commit_valid = 1'b0;
        wait_result(4'd5, ACC_RST, 2, 0);

        // Random traffic.
        macc = ACC_RST;
        have_instr = 1'b0;
        hold_prev = 1'b0;
        prev_data = '0;
        next_id = 4'd6;
        cur_instr = '0;
        cur_a = '0;
        cur_b = '0;
        cidx = 0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            bit draining;
            draining = (cyc >= 1500);
            if (!draining && !have_instr && $urandom_range(0, 2) != 0) begin
                f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3))
                                                : 3'($urandom_range(4, 7));
                cur_instr = enc(f3, 5'($urandom_range(0, 31)));
                if ($urandom_range(0, 9) == 0) cur_instr[6:0] = 7'b0101011;
                if ($urandom_range(0, 9) == 0) cur_instr[31:25] = 7'd1;
                cur_a = $urandom;
                cur_b = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 9));
                have_instr = 1'b1;
            end
            issue_valid = have_instr;
            issue_instr = cur_instr;
            issue_id = next_id;
            issue_rs0 = cur_a;
            issue_rs1 = cur_b;
            issue_rs_valid = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            commit_valid = 1'b0;
            cand.delete();
            foreach (mq[j]) if (mq[j].st == 0) cand.push_back(j);
            if (cand.size() > 0 && (draining || $urandom_range(0, 2) == 0)) begin
                cidx = cand[$urandom_range(0, cand.size() - 1)];
                commit_valid = 1'b1;
                commit_id = mq[cidx].id;
                commit_kill = !draining && ($urandom_range(0, 3) == 0);
            end
            result_ready = draining || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (hold_prev) check("rand_hold_data", result_data, prev_data);
            if (have_instr) begin
                f3 = cur_instr[14:12];
                exp_acc = (cur_instr[6:0] == OPC) && (cur_instr[31:25] == 7'd0) && (f3 < 3'd4);
                rs_ok = (f3 == 3'd0) ? issue_rs_valid[0] :
                        (f3 == 3'd1) ? (&issue_rs_valid) : 1'b1;
                check("rand_accept", issue_accept, 32'(exp_acc));
                if (exp_acc && !rs_ok) check("rand_ready_no_rs", issue_ready, 0);
            end
            if (commit_valid) mq[cidx].st = commit_kill ? 2 : 1;
            if (have_instr && issue_ready) begin
                if (exp_acc) begin
                    np.id = next_id;
                    np.f3 = f3;
                    np.a = cur_a;
                    np.b = cur_b;
                    np.st = 0;
                    mq.push_back(np);
                end
                have_instr = 1'b0;
                next_id = next_id + 1'b1;
            end
            resolve();
            if (result_valid && result_ready) begin
                if (eq.size() == 0) begin
                    check("rand_unexpected_result", result_valid, 0);
                end else begin
                    check("rand_res_id", 32'(result_id), 32'(eq[0].id));
                    check("rand_res_data", result_data, eq[0].data);
                    check("rand_res_we", result_we, 1);
                    void'(eq.pop_front());
                end
            end
            hold_prev = result_valid && !result_ready;
            prev_data = result_data;
            @(posedge clk);
            #1;
            if (draining && mq.size() == 0 && eq.size() == 0 && !have_instr && !busy) break;
        end
        issue_valid = 1'b0;
        commit_valid = 1'b0;
        check("drain_results_left", 32'(eq.size()), 0);
        check("drain_pending_left", 32'(mq.size()), 0);
        @(negedge clk);
        check("drain_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
